pipeline_stall_controller: RTL and testbench

//   Sequences stall, freeze and flush for the 5-stage MIPS pipeline (branch resolved in ID).

---
 rtl/pipeline_stall_controller.sv | 100 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 98 +++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/freeze/flush sequencing for a 5-stage MIPS pipe, optional STALL_COUNTERS_EN perf counters
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ID_opc,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             eq,
  input  logic             EX_memread,
  input  logic             EX_regwrite,
  input  logic [4:0]       EX_dst,
  input  logic             MEM_access,
  input  logic             dmem_ready,
  output logic             pc_ld,
  output logic             IF_ID_ld,
  output logic             IF_ID_flush,
  output logic             ID_EX_ld,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_ld,
  output logic             MEM_WB_bubble,
  output logic [1:0]       pc_sel,
  output logic [1:0]       ctrl_state,
  output logic             timeout_err
`ifdef STALL_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, MEM_WAIT = 2'b10, ERR = 2'b11} state_t;
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW:0]   wait_nxt;
  logic          stall_pend;
  logic          beq, bne, jmp, is_br, match, lu, bh, take, freeze, hold, stall, tk;
  assign beq      = ID_opc == 6'b000100;
  assign bne      = ID_opc == 6'b000101;
  assign jmp      = ID_opc == 6'b000010;
  assign is_br    = beq | bne;
  assign match    = (EX_dst != 5'd0) & ((EX_dst == ID_rs) | (EX_dst == ID_rt));
  assign lu       = EX_memread & match;
  assign bh       = is_br & EX_regwrite & match;
  assign take     = (beq & eq) | (bne & ~eq) | jmp;
  assign freeze   = MEM_access & ~dmem_ready;
  assign hold     = rst | (state == ERR) | freeze;
  assign stall    = ~hold & (lu | bh | (state == STALL));
  assign tk       = ~hold & ~stall & take;
  assign wait_nxt = {1'b0, wait_cnt} + 1'b1;
  assign pc_ld         = ~hold & ~stall;
  assign IF_ID_ld      = ~hold & ~stall;
  assign IF_ID_flush   = tk;
  assign ID_EX_ld      = ~hold;
  assign ID_EX_bubble  = stall;
  assign EX_MEM_ld     = ~hold;
  assign MEM_WB_bubble = hold;
  assign pc_sel        = tk ? (jmp ? 2'b10 : 2'b01) : 2'b00;
  assign ctrl_state    = state;
  // control FSM: a frozen cycle counts toward the timeout even when it is the first one seen from RUN or STALL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_pend  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (state != ERR && freeze) begin
      stall_pend <= stall_pend | (state == STALL);
      if (wait_nxt >= (WW+1)'(MEM_TIMEOUT)) begin
        state       <= ERR;
        timeout_err <= 1'b1;
        wait_cnt    <= '0;
      end else begin
        state    <= MEM_WAIT;
        wait_cnt <= wait_nxt[WW-1:0];
      end
    end else if (state != ERR) begin
      state      <= (stall_pend | (is_br & lu & (state != STALL))) ? STALL : RUN;
      wait_cnt   <= '0;
      stall_pend <= 1'b0;
    end
  end
`ifdef STALL_COUNTERS_EN
  // saturating counts of cycles where stall, take-flush or freeze is applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (tk && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
      if (hold && ~&freeze_cnt) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;
  logic       clk = 1'b0, rst = 1'b0;
  logic [5:0] ID_opc = '0;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_dst = '0;
  logic       eq = 1'b0, EX_memread = 1'b0, EX_regwrite = 1'b0, MEM_access = 1'b0, dmem_ready = 1'b1;
  logic       pc_ld, IF_ID_ld, IF_ID_flush, ID_EX_ld, ID_EX_bubble, EX_MEM_ld, MEM_WB_bubble, timeout_err;
  logic [1:0] pc_sel, ctrl_state;
`ifdef STALL_COUNTERS_EN
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
`endif
  pipeline_stall_controller dut (
    .clk(clk), .rst(rst), .ID_opc(ID_opc), .ID_rs(ID_rs), .ID_rt(ID_rt), .eq(eq),
    .EX_memread(EX_memread), .EX_regwrite(EX_regwrite), .EX_dst(EX_dst),
    .MEM_access(MEM_access), .dmem_ready(dmem_ready), .pc_ld(pc_ld), .IF_ID_ld(IF_ID_ld),
    .IF_ID_flush(IF_ID_flush), .ID_EX_ld(ID_EX_ld), .ID_EX_bubble(ID_EX_bubble),
    .EX_MEM_ld(EX_MEM_ld), .MEM_WB_bubble(MEM_WB_bubble), .pc_sel(pc_sel),
    .ctrl_state(ctrl_state), .timeout_err(timeout_err)
`ifdef STALL_COUNTERS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );
  always #5 clk = ~clk;
  localparam logic [5:0] ADD = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  localparam logic [8:0] N = 9'b1101010_00, S = 9'b0001110_00, T = 9'b1111010_01, J = 9'b1111010_10, F = 9'b0000001_00;
  localparam logic [1:0] RUN = 2'b00, STL = 2'b01, MW = 2'b10, ERR = 2'b11;
  typedef struct {int id; logic [11:0] v;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int total = 0, bad = 0, n = 0;
  logic [11:0] obs;
  assign obs = {pc_ld, IF_ID_ld, IF_ID_flush, ID_EX_ld, ID_EX_bubble, EX_MEM_ld, MEM_WB_bubble, pc_sel, ctrl_state, timeout_err};
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic step(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic e,
                      input logic mr, input logic rw, input logic [4:0] d, input logic ma, input logic rd,
                      input logic [8:0] x, input logic [1:0] st, input logic te);
    @(posedge clk);
    #1;
    ID_opc = o; ID_rs = s; ID_rt = t; eq = e;
    EX_memread = mr; EX_regwrite = rw; EX_dst = d; MEM_access = ma; dmem_ready = rd;
    sb.push_back('{n++, {x, st, te}});
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk($sformatf("step%0d", cur.id), obs, cur.v);
    end
  initial begin
    #1 rst = 1'b1;
    #2 chk("reset", obs, {F, RUN, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(ADD, 1, 2, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(ADD, 8, 3, 0, 1, 1, 8, 0, 1, S, RUN, 0);
    step(ADD, 8, 3, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(ADD, 4, 8, 0, 1, 1, 8, 0, 1, S, RUN, 0);
    step(ADD, 4, 8, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(BEQ, 8, 9, 0, 1, 1, 8, 0, 1, S, RUN, 0);
    step(BEQ, 8, 9, 0, 0, 0, 0, 0, 1, S, STL, 0);
    step(BEQ, 8, 9, 1, 0, 0, 0, 0, 1, T, RUN, 0);
    step(BNE, 1, 2, 0, 0, 0, 0, 0, 1, T, RUN, 0);
    step(BNE, 1, 2, 1, 0, 0, 0, 0, 1, N, RUN, 0);
    step(BEQ, 1, 2, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(JMP, 1, 2, 0, 0, 0, 0, 0, 1, J, RUN, 0);
    step(ADD, 0, 3, 0, 1, 1, 0, 0, 1, N, RUN, 0);
    step(BEQ, 5, 6, 1, 0, 1, 5, 0, 1, S, RUN, 0);
    step(BEQ, 5, 6, 1, 0, 0, 0, 0, 1, T, RUN, 0);
    step(ADD, 1, 2, 0, 0, 0, 0, 1, 0, F, RUN, 0);
    step(JMP, 1, 2, 0, 0, 0, 0, 1, 0, F, MW, 0);
    step(ADD, 1, 2, 0, 0, 0, 0, 1, 0, F, MW, 0);
    step(ADD, 1, 2, 0, 0, 0, 0, 1, 1, N, MW, 0);
    step(ADD, 1, 2, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(BEQ, 8, 9, 0, 1, 1, 8, 0, 1, S, RUN, 0);
    step(BEQ, 8, 9, 0, 0, 0, 0, 1, 0, F, STL, 0);
    step(BEQ, 8, 9, 0, 0, 0, 0, 1, 1, N, MW, 0);
    step(BEQ, 8, 9, 0, 0, 0, 0, 0, 1, S, STL, 0);
    step(BEQ, 8, 9, 1, 0, 0, 0, 0, 1, T, RUN, 0);
    for (int i = 0; i < 15; i++) step(ADD, 1, 2, 0, 0, 0, 0, 1, 0, F, (i == 0) ? RUN : MW, 0);
    step(ADD, 1, 2, 0, 0, 0, 0, 1, 0, F, ERR, 1);
    step(JMP, 1, 2, 0, 0, 0, 0, 0, 1, F, ERR, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", obs, {F, RUN, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    step(ADD, 1, 2, 0, 0, 0, 0, 0, 1, N, RUN, 0);
    step(JMP, 1, 2, 0, 0, 0, 0, 0, 1, J, RUN, 0);
    @(negedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
